int_prio_arb: RTL and testbench

INT_PRIO_ARB -- requirements
Module: int_prio_arb

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/int_prio_arb_if.sv | 30 +++
 rtl/int_prio_sel.sv | 30 +++
 rtl/int_prio_arb.sv | 98 +++++++++
 tb/tb_int_prio_arb.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the priority interrupt arbiter.
package int_ctrl_pkg;

    localparam int unsigned SPUR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2,
        ST_CLR  = 2'd3
    } arb_state_e;

    // Source ID width; never narrower than one bit.
    function automatic int unsigned idw_f(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/int_prio_arb_if.sv
// Source/CPU-facing signal bundle of the interrupt arbiter.
interface int_prio_arb_if #(
    parameter int unsigned N  = 5,
    parameter int unsigned PW = 3
);
    localparam int unsigned IDW = int_ctrl_pkg::idw_f(N);

    logic [N-1:0]                    int_pend;
    logic [N*PW-1:0]                 int_prio;
    logic [PW-1:0]                   prio_thr;
    logic                            irq_ack;
    logic                            irq_eoi;
    logic                            irq;
    logic [IDW-1:0]                  irq_id;
    logic [PW-1:0]                   irq_prio;
    logic                            busy;
    logic [N-1:0]                    int_clr;
    logic [int_ctrl_pkg::SPUR_W-1:0] spur_cnt;

    modport master (
        output int_pend, int_prio, prio_thr, irq_ack, irq_eoi,
        input  irq, irq_id, irq_prio, busy, int_clr, spur_cnt
    );

    modport slave (
        input  int_pend, int_prio, prio_thr, irq_ack, irq_eoi,
        output irq, irq_id, irq_prio, busy, int_clr, spur_cnt
    );

endinterface

// File: rtl/int_prio_sel.sv
// Combinational winner select: highest eligible priority, lowest index on ties.
module int_prio_sel #(
    parameter  int unsigned N   = 5,
    parameter  int unsigned PW  = 3,
    localparam int unsigned IDW = int_ctrl_pkg::idw_f(N)
) (
    input  logic [N-1:0]    i_pend,
    input  logic [N*PW-1:0] i_prio,
    input  logic [PW-1:0]   i_thr,
    output logic            found,
    output logic [IDW-1:0]  win_id,
    output logic [PW-1:0]   win_prio
);

    // Strict '>' against the running best keeps the lowest index on ties.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_pend[i] && (i_prio[i*PW +: PW] > i_thr) &&
                (!found || (i_prio[i*PW +: PW] > win_prio))) begin
                found    = 1'b1;
                win_id   = IDW'(i);
                win_prio = i_prio[i*PW +: PW];
            end
        end
    end

endmodule

// File: rtl/int_prio_arb.sv
// Priority interrupt arbiter: present winner, track ack/EOI, pulse source clear.
module int_prio_arb
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned PW = 3
) (
    input  logic           sys_clk,
    input  logic           sys_reset,
    int_prio_arb_if.slave  bus
);

    localparam int unsigned IDW = idw_f(N);

    arb_state_e        r_state;
    logic              r_irq;
    logic              r_busy;
    logic [IDW-1:0]    r_irq_id;
    logic [PW-1:0]     r_irq_prio;
    logic [N-1:0]      r_int_clr;
    logic [SPUR_W-1:0] r_spur_cnt;

    logic              w_found;
    logic [IDW-1:0]    w_win_id;
    logic [PW-1:0]     w_win_prio;
    logic              w_id_pend;

    int_prio_sel #(
        .N  (N),
        .PW (PW)
    ) u_sel (
        .i_pend   (bus.int_pend),
        .i_prio   (bus.int_prio),
        .i_thr    (bus.prio_thr),
        .found    (w_found),
        .win_id   (w_win_id),
        .win_prio (w_win_prio)
    );

    assign w_id_pend = bus.int_pend[r_irq_id];

    // State and all outputs update together so every output is a flop.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state    <= ST_IDLE;
            r_irq      <= 1'b0;
            r_busy     <= 1'b0;
            r_irq_id   <= '0;
            r_irq_prio <= '0;
            r_int_clr  <= '0;
            r_spur_cnt <= '0;
        end else begin
            r_int_clr <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_irq_id   <= w_win_id;
                        r_irq_prio <= w_win_prio;
                        r_irq      <= 1'b1;
                        r_state    <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // Ack takes precedence over a same-cycle withdrawal.
                    if (bus.irq_ack) begin
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SERV;
                    end else if (!w_id_pend) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_spur_cnt != '1) begin
                            r_spur_cnt <= r_spur_cnt + SPUR_W'(1);
                        end
                    end
                end
                ST_SERV: begin
                    if (bus.irq_eoi) begin
                        r_int_clr <= N'(1) << r_irq_id;
                        r_state   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.irq      = r_irq;
    assign bus.busy     = r_busy;
    assign bus.irq_id   = r_irq_id;
    assign bus.irq_prio = r_irq_prio;
    assign bus.int_clr  = r_int_clr;
    assign bus.spur_cnt = r_spur_cnt;

endmodule

// File: tb/tb_int_prio_arb.sv
// Directed self-checking bench for int_prio_arb.
module tb_int_prio_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // prio {1,4,4,2,7} and {1,4,5,2,7} for sources 0..4
    localparam logic [14:0] P_A = {3'd7, 3'd2, 3'd4, 3'd4, 3'd1};
    localparam logic [14:0] P_B = {3'd7, 3'd2, 3'd5, 3'd4, 3'd1};

    int_prio_arb_if #(.N(5), .PW(3)) bus ();

    int_prio_arb #(.N(5), .PW(3)) dut (
        .sys_clk   (clk),
        .sys_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.int_pend = '0;
        bus.int_prio = P_A;
        bus.prio_thr = '0;
        bus.irq_ack  = 1'b0;
        bus.irq_eoi  = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_irq",  32'(bus.irq), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_clr",  32'(bus.int_clr), 0);
        chk("rst_id",   32'(bus.irq_id), 0);
        chk("rst_prio", 32'(bus.irq_prio), 0);
        chk("rst_spur", 32'(bus.spur_cnt), 0);
        rst = 1'b0;
        tick();

        // tie at prio 4 above thr 3: lowest index wins, 1-cycle latency
        bus.prio_thr = 3'd3;
        bus.int_pend = 5'b00110;
        chk("t1_irq_pre", 32'(bus.irq), 0);
        tick();
        chk("t1_irq",  32'(bus.irq), 1);
        chk("t1_id",   32'(bus.irq_id), 1);
        chk("t1_prio", 32'(bus.irq_prio), 4);
        bus.int_pend = 5'b10110;
        tick();
        chk("t1_hold_id",  32'(bus.irq_id), 1);
        chk("t1_hold_irq", 32'(bus.irq), 1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("t1_serv_irq",  32'(bus.irq), 0);
        chk("t1_serv_busy", 32'(bus.busy), 1);
        bus.irq_eoi = 1'b1;
        tick();
        bus.irq_eoi = 1'b0;
        chk("t1_clr",      32'(bus.int_clr), 32'b00010);
        chk("t1_clr_busy", 32'(bus.busy), 1);
        bus.int_pend = '0;
        tick();
        chk("t1_idle_clr",  32'(bus.int_clr), 0);
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_idle_id",   32'(bus.irq_id), 1);

        // thr 0: source 4 (prio 7) beats source 0; full ack/eoi cycle
        bus.prio_thr = 3'd0;
        bus.int_pend = 5'b10001;
        tick();
        chk("t2_id",   32'(bus.irq_id), 4);
        chk("t2_prio", 32'(bus.irq_prio), 7);
        chk("t2_busy_pend", 32'(bus.busy), 0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("t2_busy_serv", 32'(bus.busy), 1);
        tick();
        chk("t2_busy_serv2", 32'(bus.busy), 1);
        chk("t2_clr_serv",   32'(bus.int_clr), 0);
        bus.irq_eoi = 1'b1;
        tick();
        bus.irq_eoi = 1'b0;
        chk("t2_clr",      32'(bus.int_clr), 32'b10000);
        chk("t2_clr_busy", 32'(bus.busy), 1);
        bus.int_pend = '0;
        tick();
        chk("t2_clr_once", 32'(bus.int_clr), 0);
        chk("t2_busy_end", 32'(bus.busy), 0);

        // withdrawn request counts as spurious
        bus.int_prio = P_B;
        bus.prio_thr = 3'd3;
        bus.int_pend = 5'b00100;
        tick();
        chk("t3_irq", 32'(bus.irq), 1);
        chk("t3_id",  32'(bus.irq_id), 2);
        bus.int_pend = '0;
        tick();
        chk("t3_irq_fall", 32'(bus.irq), 0);
        chk("t3_spur1",    32'(bus.spur_cnt), 1);

        // eoi in PEND ignored; ack with same-cycle withdrawal enters SERV
        bus.int_pend = 5'b00100;
        tick();
        bus.irq_eoi = 1'b1;
        tick();
        bus.irq_eoi = 1'b0;
        chk("t4_eoi_ign_irq", 32'(bus.irq), 1);
        chk("t4_eoi_ign_clr", 32'(bus.int_clr), 0);
        bus.irq_ack  = 1'b1;
        bus.int_pend = '0;
        tick();
        bus.irq_ack = 1'b0;
        chk("t4_busy", 32'(bus.busy), 1);
        chk("t4_irq",  32'(bus.irq), 0);
        chk("t4_spur", 32'(bus.spur_cnt), 1);
        bus.irq_eoi = 1'b1;
        tick();
        bus.irq_eoi = 1'b0;
        chk("t4_clr", 32'(bus.int_clr), 32'b00100);
        tick();

        // 300 spurious in total saturates at 255
        for (int k = 0; k < 299; k++) begin
            bus.int_pend = 5'b00100;
            tick();
            bus.int_pend = '0;
            tick();
        end
        chk("t5_spur_sat", 32'(bus.spur_cnt), 255);

        // SERV ignores new urgent source and extra ack; presented after CLR
        bus.prio_thr = 3'd0;
        bus.int_pend = 5'b00001;
        tick();
        chk("t6_id0", 32'(bus.irq_id), 0);
        bus.irq_ack = 1'b1;
        tick();
        bus.int_pend = 5'b10001;
        tick();
        bus.irq_ack = 1'b0;
        chk("t6_serv_busy", 32'(bus.busy), 1);
        chk("t6_serv_irq",  32'(bus.irq), 0);
        chk("t6_serv_id",   32'(bus.irq_id), 0);
        bus.irq_eoi = 1'b1;
        tick();
        bus.irq_eoi = 1'b0;
        chk("t6_clr", 32'(bus.int_clr), 32'b00001);
        bus.int_pend = 5'b10000;
        tick();
        chk("t6_idle_irq", 32'(bus.irq), 0);
        tick();
        chk("t6_new_irq", 32'(bus.irq), 1);
        chk("t6_new_id",  32'(bus.irq_id), 4);

        // reset during SERV aborts with no clear pulse
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("t7_serv_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        bus.irq_eoi = 1'b1;
        tick();
        rst = 1'b0;
        bus.irq_eoi = 1'b0;
        chk("t7_irq",  32'(bus.irq), 0);
        chk("t7_busy", 32'(bus.busy), 0);
        chk("t7_clr",  32'(bus.int_clr), 0);
        chk("t7_id",   32'(bus.irq_id), 0);
        chk("t7_prio", 32'(bus.irq_prio), 0);
        chk("t7_spur", 32'(bus.spur_cnt), 0);
        tick();
        chk("t7_resume_irq", 32'(bus.irq), 1);
        chk("t7_resume_id",  32'(bus.irq_id), 4);
        chk("t7_resume_clr", 32'(bus.int_clr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
